// File: rtl/program_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// The loader's FSM state encoding and byte/checksum widths live here.
package program_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CSUM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    CHECK,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Assembles a little-endian byte stream into instruction words, writes them to
// instruction memory in order and releases the CPU only after a valid checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INSTRUCTION_LEN      = 16,
  parameter int unsigned INSTRUCTION_MEM_SIZE = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    byte_valid,
  input  logic [BYTE_W-1:0]                       byte_data,
  output logic                                    byte_ready,
  output logic                                    imem_we,
  output logic [$clog2(INSTRUCTION_MEM_SIZE)-1:0] imem_addr,
  output logic [INSTRUCTION_LEN-1:0]              imem_wdata,
  output logic                                    busy,
  output logic                                    cpu_run,
  output logic                                    err
);

  localparam int unsigned AddrW = $clog2(INSTRUCTION_MEM_SIZE);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(INSTRUCTION_MEM_SIZE - 1);

  loader_state_t               state_q, state_d;
  logic [AddrW-1:0]            idx_q, idx_d;
  logic [CSUM_W-1:0]           acc_q, acc_d;
  logic [BYTE_W-1:0]           lo_q, lo_d;
  logic                        we_q, we_d;
  logic [AddrW-1:0]            addr_q, addr_d;
  logic [INSTRUCTION_LEN-1:0]  wdata_q, wdata_d;
  logic [CSUM_W-1:0]           acc_sum;

  // byte_ready depends on state only; valid never feeds back into it.
  always_comb begin
    byte_ready = (state_q == LOAD_LO) || (state_q == LOAD_HI) || (state_q == CHECK);
    busy       = byte_ready;
    cpu_run    = (state_q == RUN);
    err        = (state_q == ERR);
    imem_we    = we_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_sum = acc_q + byte_data;

    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d = LOAD_LO;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      LOAD_LO: begin
        if (byte_valid) begin
          lo_d    = byte_data;
          acc_d   = acc_sum;
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (byte_valid) begin
          acc_d   = acc_sum;
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = {byte_data, lo_q};
          if (idx_q == LastIdx) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + AddrW'(1);
            state_d = LOAD_LO;
          end
        end
      end
      CHECK: begin
        if (byte_valid) begin
          state_d = (acc_sum == '0) ? RUN : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset has priority, so a write pending from the same edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of the multi-cycle 16-bit processor. It accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit instructions. It writes them sequentially into the processor's instruction memory and verifies a trailing checksum byte. Only after a clean load does it assert `cpu_run`, releasing the processor.

## Interface
- `INSTRUCTION_LEN`, 16, instruction width in bits; fixed at 16 (two bytes per instruction).
- `INSTRUCTION_MEM_SIZE`, 8, number of instruction words loaded per program.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: begin load; honoured only in IDLE, RUN and ERR.
- `byte_valid` input 1: upstream byte present.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output $clog2(INSTRUCTION_MEM_SIZE): write address.
- `imem_wdata` output INSTRUCTION_LEN: write data.
- `busy` output 1: load in progress (LOAD_LO, LOAD_HI, CHECK).
- `cpu_run` output 1: program loaded and verified; processor may execute.
- `err` output 1: checksum mismatch on the last load.

## Operation
- Handshake: a byte transfers on a cycle where `byte_valid && byte_ready`. `byte_ready` is a function of state only, never of `byte_valid`.
- States:
  - IDLE: `byte_ready` is 0. `start` → LOAD_LO, with word index and checksum accumulator cleared.
  - LOAD_LO: `byte_ready` is 1. On transfer, latch the byte as `[7:0]`, add it to the accumulator, → LOAD_HI.
  - LOAD_HI: `byte_ready` is 1. On transfer, the word is `{byte, low}` and the byte is added to the accumulator.
    - Word index = `INSTRUCTION_MEM_SIZE-1`: → CHECK.
    - Otherwise: increment the index, → LOAD_LO.
  - CHECK: `byte_ready` is 1. On transfer, `(acc + byte) mod 256 == 0` → RUN; otherwise → ERR.
  - RUN: `cpu_run` is 1, `byte_ready` is 0. `start` → LOAD_LO, and `cpu_run` clears.
  - ERR: `err` is 1, `byte_ready` is 0. `start` → LOAD_LO, and `err` clears.
- Checksum: 8-bit accumulator, wrap-around addition over all 2×`INSTRUCTION_MEM_SIZE` data bytes. The sender's checksum byte is the two's complement of that sum.
- Write port:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered. The write occurs in the cycle after the high-byte transfer.
  - `imem_addr` and `imem_wdata` hold their last values when `imem_we` is 0.
  - Exactly `INSTRUCTION_MEM_SIZE` writes per load, at addresses 0 .. `INSTRUCTION_MEM_SIZE-1` in order.
- Memory contents are written even if the checksum later fails. `cpu_run` gates their use.
- `start` while `busy` is ignored; the load continues unaffected.
- Bubbles (`byte_valid` low) stall the FSM in its current state with no side effects.

## Timing
- Reset: state IDLE. All outputs are 0, including `imem_addr` and `imem_wdata`. The accumulator and index are 0.
- Reset mid-load takes effect on the next edge:
  - any pending write is suppressed;
  - `cpu_run` and `err` stay 0.
- `start` seen at edge N: `busy` and `byte_ready` are 1 from cycle N+1.
- In RUN, `cpu_run` falls in cycle N+1 after `start` at edge N.
- High byte of word k transferred at edge N: `imem_we` is 1 with `imem_addr`=k during cycle N+1. `byte_ready` may be 1 in that same cycle.
- Checksum byte transferred at edge N:
  - `cpu_run` (or `err`) is 1 from cycle N+1;
  - `busy` is 0 from cycle N+1.
- The last word's write (cycle after its high byte) always precedes `cpu_run`.
- Minimum load time: 2×`INSTRUCTION_MEM_SIZE`+1 accepted bytes, plus 1 cycle from `start`.

## Structure
- Package `program_loader_pkg` holds:
  - the `loader_state_t` enum (IDLE, LOAD_LO, LOAD_HI, CHECK, RUN, ERR);
  - `BYTE_W = 8`;
  - `CSUM_W = 8`.
- Single module; no sub-module is needed. The accumulator and byte assembler are a few registers inside the FSM.

## Test plan
- Nominal load, `INSTRUCTION_MEM_SIZE`=8, bytes 0x01..0x10 then checksum 0x78:
  - writes addr 0..7 with data 0x0201, 0x0403, …, 0x100F;
  - `cpu_run`=1 the cycle after the checksum byte; `err`=0.
- Same stream with checksum 0x77:
  - all 8 writes occur;
  - `err`=1, `cpu_run`=0, `byte_ready`=0 afterwards.
- Nominal stream with `byte_valid` low on every other cycle and a 5-cycle gap mid-word: identical writes and result; no write while stalled.
- In RUN, pulse `start` and reload 16 bytes of 0x00 with checksum 0x00:
  - `cpu_run` drops the next cycle;
  - 8 writes of 0x0000;
  - `cpu_run` returns to 1.
- Pulse `start` while in LOAD_HI of word 2: ignored; the load completes normally.
- Assert `reset` after word 3's high byte: no write in the next cycle; all outputs 0; state IDLE; bytes presented afterwards are not accepted.
